wide_adder_seq_ctrl: RTL and testbench

- Sequencer for the shared combinational wide adder (WIDTH-bit A/B/Cin -> WIDTH-bit sum, 1-bit carry).
- Performs a multi-precision add of NWORDS*WIDTH-bit operands by feeding the adder one WIDTH-bit word per cycle, least-significant word first, and chaining the carry through a register.
- Sits between a requester (start/busy/done handshake) and the adder instance, which is external and connected through the add_* ports.

---
 rtl/wide_adder_seq_ctrl.sv | 107 ++++++++++
 tb/tb_wide_adder_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wide_adder_seq_ctrl.sv
// wide_adder_seq_ctrl: multi-word add sequencer for an external WIDTH-bit adder; define WIDE_ADDER_SEQ_SUB_EN to add sub_in (A-B)
module wide_adder_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NWORDS*WIDTH-1:0] a_in,
  input  logic [NWORDS*WIDTH-1:0] b_in,
  input  logic                    cin_in,
`ifdef WIDE_ADDER_SEQ_SUB_EN
  input  logic                    sub_in,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [NWORDS*WIDTH-1:0] sum_out,
  output logic                    cout_out,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cin_q, cin_d, sub_q, sub_d, cout_q, cout_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [NWORDS-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic sub_start, run;
`ifdef WIDE_ADDER_SEQ_SUB_EN
  assign sub_start = sub_in;
`else
  assign sub_start = 1'b0;
`endif
  assign run      = state_q == RUN;
  assign add_a    = run ? a_q[idx_q] : '0;
  assign add_b    = run ? (sub_q ? ~b_q[idx_q] : b_q[idx_q]) : '0;
  assign add_cin  = run ? ((idx_q == '0) ? cin_q : carry_q) : 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
  // next state: latch operands on start, retire one word per RUN cycle, chain carry
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cin_d   = cin_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        sub_d   = sub_start;
        cin_d   = sub_start ? 1'b1 : cin_in;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        cout_d       = (idx_q == LAST) ? add_cout : cout_q;
        state_d      = (idx_q == LAST) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  // state and registered outputs, synchronous reset wins over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_wide_adder_seq_ctrl.sv
// tb_wide_adder_seq_ctrl: directed and random checks of the wide add sequencer against an arithmetic model
module tb_wide_adder_seq_ctrl;
  localparam int WIDTH = 4, NWORDS = 4, OW = WIDTH * NWORDS;
  logic clk = 1'b0, reset, start, cin_in, busy, done, cout_out, add_cin, add_cout, sub_v;
  logic [OW-1:0] a_in, b_in, sum_out;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
`ifdef WIDE_ADDER_SEQ_SUB_EN
  logic sub_in;
  assign sub_in = sub_v;
`endif
  int n_chk = 0, n_fail = 0, busy_cnt;
  logic [WIDTH-1:0] seq_a[$], seq_b[$];

  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

  wide_adder_seq_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
`ifdef WIDE_ADDER_SEQ_SUB_EN
    .sub_in(sub_in),
`endif
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  function automatic logic [OW:0] ref_add(input logic [OW-1:0] a, b, input logic c, s);
    return s ? ({1'b0, a} + {1'b0, ~b} + (OW+1)'(1)) : ({1'b0, a} + {1'b0, b} + (OW+1)'(c));
  endfunction

  task automatic pulse_start(input logic [OW-1:0] a, b, input logic c, s);
    a_in = a; b_in = b; cin_in = c; sub_v = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1; busy_cnt = 0; seq_a.delete(); seq_b.delete();
    while (!done && cyc < 30) begin
      if (busy) begin busy_cnt++; seq_a.push_back(add_a); seq_b.push_back(add_b); end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_v = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum_out); end
    n_chk++; if (cout_out !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout_out); end
    n_chk++; if ({add_a, add_b, add_cin} !== '0) begin n_fail++; $display("FAIL reset_adder_drive got %h/%h/%b want 0", add_a, add_b, add_cin); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_carry_ripple;
    int cyc;
    pulse_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    n_chk++; if (cyc !== NWORDS + 1) begin n_fail++; $display("FAIL ripple_latency got %0d want %0d", cyc, NWORDS + 1); end
    n_chk++; if (busy_cnt !== NWORDS) begin n_fail++; $display("FAIL ripple_busy_cycles got %0d want %0d", busy_cnt, NWORDS); end
    n_chk++; if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum got %h want 0000", sum_out); end
    n_chk++; if (cout_out !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got %b want 1", cout_out); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL ripple_done_width got %b want 0", done); end
  endtask

  task automatic test_plain_add;
    int cyc;
    logic [OW-1:0] a = 16'h1234, b = 16'h4321;
    pulse_start(a, b, 1'b1, 1'b0);
    wait_done(cyc);
    n_chk++; if (sum_out !== 16'h5556) begin n_fail++; $display("FAIL plain_sum got %h want 5556", sum_out); end
    n_chk++; if (cout_out !== 1'b0) begin n_fail++; $display("FAIL plain_cout got %b want 0", cout_out); end
    n_chk++; if (seq_a.size() !== NWORDS) begin n_fail++; $display("FAIL plain_seq_len got %0d want %0d", seq_a.size(), NWORDS); end
    else for (int i = 0; i < NWORDS; i++) begin
      n_chk++; if (seq_a[i] !== a[i*WIDTH +: WIDTH] || seq_b[i] !== b[i*WIDTH +: WIDTH]) begin
        n_fail++; $display("FAIL plain_word%0d got a=%h b=%h want a=%h b=%h", i, seq_a[i], seq_b[i], a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int dn = 0;
    logic [OW:0] exp = ref_add(16'h0F0F, 16'h1111, 1'b0, 1'b0);
    pulse_start(16'h0F0F, 16'h1111, 1'b0, 1'b0);
    a_in = 16'h0001; b_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin if (done) dn++; @(negedge clk); end
    n_chk++; if (dn !== 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", dn); end
    n_chk++; if ({cout_out, sum_out} !== exp) begin n_fail++; $display("FAIL busy_start_result got %h want %h", {cout_out, sum_out}, exp); end
  endtask

  task automatic test_reset_mid_run;
    int cyc, dn = 0;
    logic [OW:0] exp = ref_add(16'h8421, 16'h7BDE, 1'b1, 1'b0);
    pulse_start(16'hABCD, 16'h1357, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_chk++; if (sum_out !== '0) begin n_fail++; $display("FAIL midreset_sum got %h want 0", sum_out); end
    n_chk++; if (cout_out !== 1'b0) begin n_fail++; $display("FAIL midreset_cout got %b want 0", cout_out); end
    repeat (6) begin if (done) dn++; @(negedge clk); end
    n_chk++; if (dn !== 0) begin n_fail++; $display("FAIL midreset_done_count got %0d want 0", dn); end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_with_start_busy got %b want 0", busy); end
    pulse_start(16'h8421, 16'h7BDE, 1'b1, 1'b0);
    wait_done(cyc);
    n_chk++; if ({cout_out, sum_out} !== exp) begin n_fail++; $display("FAIL midreset_rerun got %h want %h", {cout_out, sum_out}, exp); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [OW:0] e1 = ref_add(16'h9999, 16'h6667, 1'b0, 1'b0), e2 = ref_add(16'h0102, 16'h0304, 1'b1, 1'b0);
    pulse_start(16'h9999, 16'h6667, 1'b0, 1'b0);
    wait_done(cyc);
    n_chk++; if ({cout_out, sum_out} !== e1) begin n_fail++; $display("FAIL b2b_first got %h want %h", {cout_out, sum_out}, e1); end
    @(negedge clk);
    pulse_start(16'h0102, 16'h0304, 1'b1, 1'b0);
    wait_done(cyc);
    n_chk++; if (cyc !== NWORDS + 1) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", cyc, NWORDS + 1); end
    n_chk++; if ({cout_out, sum_out} !== e2) begin n_fail++; $display("FAIL b2b_second got %h want %h", {cout_out, sum_out}, e2); end
    @(negedge clk);
  endtask

`ifdef WIDE_ADDER_SEQ_SUB_EN
  task automatic test_sub;
    int cyc;
    pulse_start(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(cyc);
    n_chk++; if (sum_out !== 16'hFFFE) begin n_fail++; $display("FAIL sub_sum got %h want fffe", sum_out); end
    n_chk++; if (cout_out !== 1'b0) begin n_fail++; $display("FAIL sub_cout got %b want 0", cout_out); end
    @(negedge clk);
  endtask
`endif

  task automatic test_random;
    int cyc;
    logic [OW-1:0] a, b;
    logic c, s;
    logic [OW:0] exp;
    for (int k = 0; k < 20; k++) begin
      a = OW'($urandom); b = OW'($urandom); c = 1'($urandom);
`ifdef WIDE_ADDER_SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp = ref_add(a, b, c, s);
      pulse_start(a, b, c, s);
      wait_done(cyc);
      n_chk++; if (cyc !== NWORDS + 1 || {cout_out, sum_out} !== exp) begin
        n_fail++; $display("FAIL random%0d got %h lat %0d want %h lat %0d", k, {cout_out, sum_out}, cyc, exp, NWORDS + 1);
      end
      if ($urandom_range(1)) @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_carry_ripple;
    test_plain_add;
    test_start_while_busy;
    test_reset_mid_run;
    test_back_to_back;
`ifdef WIDE_ADDER_SEQ_SUB_EN
    test_sub;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
